// File: rtl/save_image_mul_pipe.sv
// Pipelined multiplier with valid/ready flow control, per-operand signedness,
// optional rounding right shift and optional saturation of the result.
module save_image_mul_pipe #(
    parameter int DIN0_WIDTH  = 17,
    parameter int DIN1_WIDTH  = 12,
    parameter bit DIN0_SIGNED = 1'b1,
    parameter bit DIN1_SIGNED = 1'b0,
    parameter int DOUT_WIDTH  = 29,
    parameter int NUM_STAGE   = 3,
    parameter int SHIFT       = 0,
    parameter bit SATURATE    = 1'b0,
    parameter int TAG_WIDTH   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic                  out_ovf
);

    localparam int FULL_W     = DIN0_WIDTH + DIN1_WIDTH;
    localparam int PROD_W     = FULL_W + 2;
    // One bit of headroom above the exact product so the rounding add cannot wrap.
    localparam int RW         = FULL_W + 3;
    localparam bit RES_SIGNED = DIN0_SIGNED | DIN1_SIGNED;
    localparam int RS         = (NUM_STAGE > 1) ? 1 : 0;
    localparam int HI_EXP     = RES_SIGNED ? DOUT_WIDTH - 1 : DOUT_WIDTH;
    localparam int RND_SH     = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic signed [RW-1:0] ONE  = RW'(1);
    localparam logic signed [RW-1:0] HI_B = (ONE <<< HI_EXP) - ONE;
    localparam logic signed [RW-1:0] LO_B = RES_SIGNED ? -(ONE <<< HI_EXP) : '0;
    localparam logic signed [RW-1:0] RND  = (SHIFT > 0) ? (ONE <<< RND_SH) : '0;

    if (DIN0_WIDTH < 2 || DIN0_WIDTH > 32 ||
        DIN1_WIDTH < 2 || DIN1_WIDTH > 32 ||
        DOUT_WIDTH < 2 || DOUT_WIDTH > FULL_W ||
        NUM_STAGE < 1 || NUM_STAGE > 8 ||
        SHIFT < 0 || SHIFT > FULL_W - 1 ||
        TAG_WIDTH < 1) begin : g_bad_param
        $error("save_image_mul_pipe: parameter out of legal range");
    end

    logic adv;

    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

    // Operand source: registered in stage 0 when the pipe is deep enough,
    // otherwise the whole datapath sits in front of the single stage.
    logic [DIN0_WIDTH-1:0] a_src;
    logic [DIN1_WIDTH-1:0] b_src;

    if (NUM_STAGE > 1) begin : g_opreg
        logic [DIN0_WIDTH-1:0] a_q;
        logic [DIN1_WIDTH-1:0] b_q;

        always_ff @(posedge clk) begin
            if (adv) begin
                a_q <= din0;
                b_q <= din1;
            end
        end

        assign a_src = a_q;
        assign b_src = b_q;
    end else begin : g_opdirect
        assign a_src = din0;
        assign b_src = din1;
    end

    logic signed [DIN0_WIDTH:0] a_x;
    logic signed [DIN1_WIDTH:0] b_x;
    logic signed [PROD_W-1:0]   prod;
    logic signed [RW-1:0]       prod_w;
    logic signed [RW-1:0]       rounded;

    assign a_x     = {(DIN0_SIGNED ? a_src[DIN0_WIDTH-1] : 1'b0), a_src};
    assign b_x     = {(DIN1_SIGNED ? b_src[DIN1_WIDTH-1] : 1'b0), b_src};
    assign prod    = PROD_W'(a_x) * PROD_W'(b_x);
    assign prod_w  = RW'(prod);
    assign rounded = (prod_w + RND) >>> SHIFT;

    logic                  over;
    logic                  under;
    logic                  fit_ovf;
    logic [DOUT_WIDTH-1:0] fit_dout;

    always_comb begin
        over     = rounded > HI_B;
        under    = rounded < LO_B;
        fit_ovf  = over | under;
        fit_dout = rounded[DOUT_WIDTH-1:0];
        if (SATURATE && over) begin
            fit_dout = HI_B[DOUT_WIDTH-1:0];
        end else if (SATURATE && under) begin
            fit_dout = LO_B[DOUT_WIDTH-1:0];
        end
    end

    // Valid and tag travel from stage 0; result and overflow join at stage RS.
    logic [NUM_STAGE-1:0]  vld_q;
    logic [TAG_WIDTH-1:0]  tag_q [NUM_STAGE];
    logic [DOUT_WIDTH-1:0] res_q [RS:NUM_STAGE-1];
    logic [NUM_STAGE-1:RS] ovf_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            ovf_q <= '0;
            for (int i = 0; i < NUM_STAGE; i++) begin
                tag_q[i] <= '0;
            end
            for (int i = RS; i < NUM_STAGE; i++) begin
                res_q[i] <= '0;
            end
        end else if (adv) begin
            vld_q[0]  <= in_valid;
            tag_q[0]  <= in_tag;
            res_q[RS] <= fit_dout;
            ovf_q[RS] <= fit_ovf;
            for (int i = 1; i < NUM_STAGE; i++) begin
                vld_q[i] <= vld_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end
            for (int i = RS + 1; i < NUM_STAGE; i++) begin
                res_q[i] <= res_q[i-1];
                ovf_q[i] <= ovf_q[i-1];
            end
        end
    end

    assign out_valid = vld_q[NUM_STAGE-1];
    assign dout      = res_q[NUM_STAGE-1];
    assign out_tag   = tag_q[NUM_STAGE-1];
    assign out_ovf   = ovf_q[NUM_STAGE-1];

endmodule

// File: tb/tb_save_image_mul_pipe.sv
// Bench for save_image_mul_pipe: default-config stream against a reference
// model plus directed checks on saturating, wrapping, shifting and unsigned variants.
module tb_save_image_mul_pipe;

  localparam int TW = 8;
  localparam int W  = TW + 29 + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b0;
  logic [16:0]   din0      = '0;
  logic [11:0]   din1      = '0;
  logic [TW-1:0] in_tag    = '0;
  logic          in_ready;
  logic          out_valid;
  logic          out_ovf;
  logic [28:0]   dout;
  logic [TW-1:0] out_tag;

  save_image_mul_pipe #(.TAG_WIDTH(TW)) u_dut (
    .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(in_ready),
    .din0(din0), .din1(din1), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .dout(dout), .out_tag(out_tag), .out_ovf(out_ovf)
  );

  logic [31:0] aux_a     = '0;
  logic [31:0] aux_b     = '0;
  logic [3:0]  aux_valid = '0;
  wire  [3:0]  aux_ov;
  wire  [3:0]  aux_ir;
  wire  [3:0]  aux_ovf;
  wire  [3:0]  aux_tago;
  wire  [15:0] sat_dout;
  wire  [15:0] wrap_dout;
  wire  [28:0] sh_dout;
  wire  [23:0] un_dout;

  save_image_mul_pipe #(.DOUT_WIDTH(16), .SATURATE(1'b1)) u_sat (
    .clk(clk), .reset(rst), .in_valid(aux_valid[0]), .in_ready(aux_ir[0]),
    .din0(aux_a[16:0]), .din1(aux_b[11:0]), .in_tag(1'b0), .out_valid(aux_ov[0]),
    .out_ready(1'b1), .dout(sat_dout), .out_tag(aux_tago[0]), .out_ovf(aux_ovf[0])
  );

  save_image_mul_pipe #(.DOUT_WIDTH(16), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .reset(rst), .in_valid(aux_valid[1]), .in_ready(aux_ir[1]),
    .din0(aux_a[16:0]), .din1(aux_b[11:0]), .in_tag(1'b0), .out_valid(aux_ov[1]),
    .out_ready(1'b1), .dout(wrap_dout), .out_tag(aux_tago[1]), .out_ovf(aux_ovf[1])
  );

  save_image_mul_pipe #(.SHIFT(4)) u_shift (
    .clk(clk), .reset(rst), .in_valid(aux_valid[2]), .in_ready(aux_ir[2]),
    .din0(aux_a[16:0]), .din1(aux_b[11:0]), .in_tag(1'b0), .out_valid(aux_ov[2]),
    .out_ready(1'b1), .dout(sh_dout), .out_tag(aux_tago[2]), .out_ovf(aux_ovf[2])
  );

  save_image_mul_pipe #(
    .DIN0_WIDTH(12), .DIN1_WIDTH(12), .DIN0_SIGNED(1'b0), .DIN1_SIGNED(1'b0), .DOUT_WIDTH(24)
  ) u_uns (
    .clk(clk), .reset(rst), .in_valid(aux_valid[3]), .in_ready(aux_ir[3]),
    .din0(aux_a[11:0]), .din1(aux_b[11:0]), .in_tag(1'b0), .out_valid(aux_ov[3]),
    .out_ready(1'b1), .dout(un_dout), .out_tag(aux_tago[3]), .out_ovf(aux_ovf[3])
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: exact signed17 x unsigned12 product, always fits 29 bits signed.
  function automatic logic [W-1:0] model(input logic [16:0] a, input logic [11:0] b,
                                         input logic [TW-1:0] t);
    longint p;
    p = longint'($signed(a)) * longint'(b);
    return {t, p[28:0], 1'b0};
  endfunction

  // Scoreboard: push on accept, pop/compare on output transfer.
  logic [W-1:0] exp_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      check("in_ready_rule", 64'(in_ready), 64'(!(out_valid && !out_ready)));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("spurious_out", 64'(out_valid), 64'd0);
        else check("stream_out", 64'({out_tag, dout, out_ovf}), 64'(exp_q.pop_front()));
      end
      if (in_valid && in_ready) exp_q.push_back(model(din0, din1, in_tag));
    end
  end

  task automatic send_lat(input logic [16:0] a, input logic [11:0] b, input logic [TW-1:0] t,
                          input logic [28:0] exp_d, input string name);
    int k;
    din0 = a; din1 = b; in_tag = t; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    k = 1;
    while (!out_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check({name, "_latency"}, 64'(k), 64'd3);
    check({name, "_dout"}, 64'(dout), 64'(exp_d));
    check({name, "_ovf"}, 64'(out_ovf), 64'd0);
    check({name, "_tag"}, 64'(out_tag), 64'(t));
    @(posedge clk); #1;
  endtask

  task automatic aux_run(input int s, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_d, input logic exp_o, input string name);
    int k;
    logic [31:0] got;
    aux_a = a; aux_b = b; aux_valid = 4'(1 << s);
    @(posedge clk); #1 aux_valid = '0;
    k = 1;
    while (!aux_ov[s] && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check({name, "_valid"}, 64'(aux_ov[s]), 64'd1);
    case (s)
      0: got = {16'b0, sat_dout};
      1: got = {16'b0, wrap_dout};
      2: got = {3'b0, sh_dout};
      default: got = {8'b0, un_dout};
    endcase
    check({name, "_dout"}, 64'(got), 64'(exp_d));
    check({name, "_ovf"}, 64'(aux_ovf[s]), 64'(exp_o));
    @(posedge clk); #1;
  endtask

  initial begin
    int sent;
    int cyc;

    // Reset values
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_dout", 64'(dout), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_out_ovf", 64'(out_ovf), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_aux_valid", 64'(aux_ov), 64'd0);
    @(negedge clk); @(posedge clk); #1 rst = 1'b0;
    out_ready = 1'b1;

    // Directed extremes of the default configuration
    send_lat(17'h10000, 12'hFFF, 8'h11, 29'(-268369920), "min_x_max");
    send_lat(17'h0FFFF, 12'hFFF, 8'h22, 29'd268365825, "max_x_max");

    // Random stream with random in_valid and ~30% out_ready low
    sent = 0;
    cyc = 0;
    while (sent < 50 && cyc < 2000) begin
      in_valid  = ($urandom_range(0, 99) < 70);
      out_ready = ($urandom_range(0, 99) >= 30);
      din0      = 17'($urandom);
      din1      = 12'($urandom);
      if ($urandom_range(0, 9) == 0) din0 = 17'h10000;
      if ($urandom_range(0, 9) == 0) din1 = 12'hFFF;
      in_tag    = TW'(sent);
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_sent", 64'(sent), 64'd50);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("stream_drained", 64'(exp_q.size()), 64'd0);

    // Configuration variants
    aux_run(0, 32'd1000, 32'd100, 32'h7FFF, 1'b1, "sat_pos");
    aux_run(0, -32'sd1000, 32'd100, 32'h8000, 1'b1, "sat_neg");
    aux_run(1, 32'd1000, 32'd100, 32'h86A0, 1'b1, "wrap_pos");
    aux_run(2, 32'd3, 32'd8, 32'd2, 1'b0, "shift_3x8");
    aux_run(2, -32'sd3, 32'd8, 32'h1FFFFFFF, 1'b0, "shift_m3x8");
    aux_run(2, 32'd5, 32'd3, 32'd1, 1'b0, "shift_5x3");
    aux_run(2, -32'sd1, 32'd1, 32'd0, 1'b0, "shift_m1x1");
    aux_run(3, 32'd4095, 32'd4095, 32'd16769025, 1'b0, "uns_max");

    // Fill the pipe while stalled, then reset mid-cycle
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      din0   = 17'($urandom);
      din1   = 12'($urandom);
      in_tag = TW'(100 + i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_out_valid", 64'(out_valid), 64'd1);
    @(negedge clk); #2 rst = 1'b1;
    exp_q.delete();
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_dout", 64'(dout), 64'd0);
    check("midrst_out_tag", 64'(out_tag), 64'd0);
    check("midrst_out_ovf", 64'(out_ovf), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_lat(17'd5, 12'd7, 8'hA5, 29'd35, "post_rst");
    check("post_rst_alone", 64'(out_valid), 64'd0);
    check("post_rst_queue", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
